cordic_rotator: RTL and testbench

//  Iterative rotation-mode CORDIC engine computing cos/sin of a signed angle in degrees.

---
 rtl/cordic_rotator.sv | 143 ++++++++++++++
 tb/tb_cordic_rotator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cordic_rotator: iterative rotation-mode CORDIC, cos/sin of a degree angle  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cordic_rotator #(
  parameter int ANG_W  = 22,
  parameter int DATA_W = 18,
  parameter int ITER   = 16,
  parameter int GUARD  = 2,
  parameter int X_INIT = 39797
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ANG_W-1:0]  angle_in,
  output logic [3:0]        lut_idx,
  input  logic [ANG_W-1:0]  lut_angle,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] cos_out,
  output logic [DATA_W-1:0] sin_out
);

  localparam int XW = DATA_W + GUARD;
  localparam logic signed [ANG_W-1:0]  c_ang_max = ANG_W'(368640);
  localparam logic signed [ANG_W-1:0]  c_ang_min = ANG_W'(-368640);
  localparam logic [3:0]               c_last    = 4'(ITER - 1);
  localparam logic signed [XW-1:0]     c_x_init  = XW'(X_INIT);
  localparam logic signed [DATA_W-1:0] c_out_max = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] c_out_min = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [XW-1:0]     c_sat_hi  = {{GUARD{1'b0}}, c_out_max};
  localparam logic signed [XW-1:0]     c_sat_lo  = {{GUARD{1'b1}}, c_out_min};

  // S_REJECT holds busy for one cycle so an out-of-range request still takes two cycles
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REJECT = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                   r_state;
  logic signed [XW-1:0]     r_x;
  logic signed [XW-1:0]     r_y;
  logic signed [ANG_W-1:0]  r_z;
  logic [3:0]               r_i;

  logic signed [XW-1:0]     w_xs;
  logic signed [XW-1:0]     w_ys;
  logic signed [XW-1:0]     w_x_nxt;
  logic signed [XW-1:0]     w_y_nxt;
  logic signed [ANG_W-1:0]  w_z_nxt;
  logic                     w_ang_bad;

  function automatic logic [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
    if (v > c_sat_hi)      sat = c_out_max;
    else if (v < c_sat_lo) sat = c_out_min;
    else                   sat = v[DATA_W-1:0];
  endfunction

  always_comb begin
    w_xs    = r_x >>> r_i;
    w_ys    = r_y >>> r_i;
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    w_z_nxt = r_z;
    if (!r_z[ANG_W-1]) begin
      w_x_nxt = r_x - w_ys;
      w_y_nxt = r_y + w_xs;
      w_z_nxt = r_z - signed'(lut_angle);
    end else begin
      w_x_nxt = r_x + w_ys;
      w_y_nxt = r_y - w_xs;
      w_z_nxt = r_z + signed'(lut_angle);
    end
  end

  assign w_ang_bad = (signed'(angle_in) > c_ang_max) || (signed'(angle_in) < c_ang_min);

  // r_i is cleared whenever RUN ends, so it doubles as the zero-outside-RUN LUT index
  assign lut_idx = r_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            r_i     <= '0;
            r_x     <= c_x_init;
            r_y     <= '0;
            r_z     <= angle_in;
            r_state <= w_ang_bad ? S_REJECT : S_RUN;
          end
        end
        S_RUN: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          if (r_i == c_last) begin
            r_i     <= '0;
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            cos_out <= sat(w_x_nxt);
            sin_out <= sat(w_y_nxt);
          end else begin
            r_i <= r_i + 4'd1;
          end
        end
        S_REJECT: begin
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          err     <= 1'b1;
          cos_out <= '0;
          sin_out <= '0;
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_rotator.sv
`default_nettype none
// Directed bench for cordic_rotator with a behavioural arctan-in-degrees LUT.
module tb_cordic_rotator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [21:0] angle_in = '0;
  logic [21:0] lut_angle;
  logic [3:0]  lut_idx;
  logic        busy;
  logic        done;
  logic        err;
  logic [17:0] cos_out;
  logic [17:0] sin_out;

  int n_checks = 0;
  int n_errors = 0;

  cordic_rotator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .angle_in  (angle_in),
    .lut_idx   (lut_idx),
    .lut_angle (lut_angle),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  always #5 clk = ~clk;

  // round(atan(2^-i) * 4096) in degrees
  function automatic logic [21:0] atan_deg(input logic [3:0] i);
    case (i)
      4'd0:    atan_deg = 22'd184320;
      4'd1:    atan_deg = 22'd108810;
      4'd2:    atan_deg = 22'd57492;
      4'd3:    atan_deg = 22'd29184;
      4'd4:    atan_deg = 22'd14649;
      4'd5:    atan_deg = 22'd7331;
      4'd6:    atan_deg = 22'd3667;
      4'd7:    atan_deg = 22'd1833;
      4'd8:    atan_deg = 22'd917;
      4'd9:    atan_deg = 22'd458;
      4'd10:   atan_deg = 22'd229;
      4'd11:   atan_deg = 22'd115;
      4'd12:   atan_deg = 22'd57;
      4'd13:   atan_deg = 22'd29;
      4'd14:   atan_deg = 22'd14;
      default: atan_deg = 22'd7;
    endcase
  endfunction

  always_comb lut_angle = atan_deg(lut_idx);

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input longint obs, input longint exp);
    logic ok;
    ok = ((obs - exp) <= 16) && ((exp - obs) <= 16);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d +-16", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, " busy"},    longint'(busy), 0);
    check_eq({tag, " done"},    longint'(done), 0);
    check_eq({tag, " err"},     longint'(err), 0);
    check_eq({tag, " cos"},     longint'($signed(cos_out)), 0);
    check_eq({tag, " sin"},     longint'($signed(sin_out)), 0);
    check_eq({tag, " lut_idx"}, longint'(lut_idx), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [21:0] a, input int exp_lat, input bit poke);
    int cyc;
    int seq_bad;
    bit seen;
    cyc = 0;
    seq_bad = 0;
    seen = 1'b0;
    start = 1'b1;
    angle_in = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    angle_in = a ^ 22'h155555;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) seq_bad++;
        if (lut_idx !== ((exp_lat == 2) ? 4'd0 : 4'(cyc - 1))) seq_bad++;
        if (poke) start = (cyc == 5);
      end
    end
    check_eq("done latency", longint'(cyc), longint'(exp_lat));
    check_eq("busy/lut_idx sequence", longint'(seq_bad), 0);
    check_eq("busy at done", longint'(busy), 0);
    check_eq("lut_idx at done", longint'(lut_idx), 0);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    check_eq("done single pulse", longint'(done), 0);
    check_eq("start on done ignored", longint'(busy), 0);
  endtask

  initial begin
    int n_seen;
    bit hit7;

    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("idle after reset");

    run_op(22'd0, 17, 1'b0);
    check_near("0deg cos", $signed(cos_out), 65536);
    check_near("0deg sin", $signed(sin_out), 0);
    check_eq("0deg err", longint'(err), 0);

    run_op(22'd122880, 17, 1'b0);
    check_near("30deg cos", $signed(cos_out), 56756);
    check_near("30deg sin", $signed(sin_out), 32768);

    run_op(-22'sd184320, 17, 1'b1);
    check_near("-45deg cos", $signed(cos_out), 46341);
    check_near("-45deg sin", $signed(sin_out), -46341);
    repeat (3) @(negedge clk);
    check_near("-45deg cos held", $signed(cos_out), 46341);

    run_op(22'd368640, 17, 1'b0);
    check_near("90deg cos", $signed(cos_out), 0);
    check_near("90deg sin", $signed(sin_out), 65536);
    check_eq("90deg err", longint'(err), 0);

    run_op(-22'sd368640, 17, 1'b0);
    check_near("-90deg cos", $signed(cos_out), 0);
    check_near("-90deg sin", $signed(sin_out), -65536);

    run_op(22'd368641, 2, 1'b1);
    check_eq("over+ err", longint'(err), 1);
    check_eq("over+ cos", longint'($signed(cos_out)), 0);
    check_eq("over+ sin", longint'($signed(sin_out)), 0);

    run_op(22'd122880, 17, 1'b0);
    check_eq("err cleared", longint'(err), 0);

    run_op(-22'sd368641, 2, 1'b0);
    check_eq("over- err", longint'(err), 1);

    run_op(22'd184320, 17, 1'b0);

    // abort an operation at iteration 7
    start = 1'b1;
    angle_in = 22'd184320;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit7 = 1'b0;
    for (int k = 0; k < 20 && !hit7; k++) begin
      @(negedge clk);
      if (lut_idx == 4'd7) hit7 = 1'b1;
    end
    check_eq("reached iteration 7", longint'(hit7), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async reset mid-op");
    @(negedge clk);
    rst_n = 1'b1;
    n_seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) n_seen++;
    end
    check_eq("no done after abort", longint'(n_seen), 0);

    run_op(22'd245760, 17, 1'b0);
    check_near("60deg cos", $signed(cos_out), 32768);
    check_near("60deg sin", $signed(sin_out), 56756);
    check_eq("60deg err", longint'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
